// File: rtl/pipelined_prefix_adder.sv
// Pipelined Kogge-Stone adder/subtractor with carry-in, carry-out, signed-overflow and zero flags.
// Latency: $clog2(WIDTH)+2 cycles from accept to out_valid; one result per cycle when unstalled.
// Backpressure: single global enable (~out_valid | out_ready) freezes every stage; in_ready mirrors it.
module pipelined_prefix_adder #(
    parameter  int WIDTH = 16,
    localparam int LOG2W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    logic adv;
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    logic             v0;
    logic [WIDTH-1:0] xa;
    logic [WIDTH-1:0] yb;
    logic             c0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v0 <= 1'b0;
            xa <= '0;
            yb <= '0;
            c0 <= 1'b0;
        end else if (adv) begin
            v0 <= in_valid;
            xa <= x;
            yb <= sub ? ~y : y;
            c0 <= sub | cin;
        end
    end

    logic [WIDTH-1:0] p0;
    assign p0 = xa ^ yb;

    // Prefix vectors are offset by one: index j holds bit j-1, index 0 is the carry-in.
    // Only bits -1..WIDTH-2 go through the tree; the MSB carry is formed in the last stage.
    for (genvar k = 1; k <= LOG2W; k++) begin : lvl
        localparam int D = 1 << (k - 1);
        localparam logic [WIDTH-1:0] LOW = (WIDTH'(1) << D) - WIDTH'(1);

        logic [WIDTH-1:0] gin;
        logic [WIDTH-1:0] pin;
        logic [WIDTH+1:0] side_in;
        logic             vin;
        logic [WIDTH-1:0] g_r;
        logic [WIDTH+1:0] side_r;
        logic             v_r;

        if (k == 1) begin : src
            assign gin     = {xa[WIDTH-2:0] & yb[WIDTH-2:0], c0};
            assign pin     = {p0[WIDTH-2:0], 1'b0};
            assign side_in = {xa[WIDTH-1], yb[WIDTH-1], p0};
            assign vin     = v0;
        end else begin : src
            assign gin     = lvl[k-1].g_r;
            assign pin     = lvl[k-1].pr.p_r;
            assign side_in = lvl[k-1].side_r;
            assign vin     = lvl[k-1].v_r;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_r    <= 1'b0;
                g_r    <= '0;
                side_r <= '0;
            end else if (adv) begin
                v_r    <= vin;
                g_r    <= gin | (pin & (gin << D));
                side_r <= side_in;
            end
        end

        // The last level's group-propagate has no consumer, so it is not kept.
        if (k < LOG2W) begin : pr
            logic [WIDTH-1:0] p_r;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    p_r <= '0;
                end else if (adv) begin
                    p_r <= pin & ((pin << D) | LOW);
                end
            end
        end
    end

    logic [WIDTH-1:0] gf;
    logic [WIDTH-1:0] hf;
    logic             xm;
    logic             ym;
    logic             vf;
    logic [WIDTH-1:0] s_nxt;
    logic             c_top;

    assign gf          = lvl[LOG2W].g_r;
    assign {xm, ym, hf} = lvl[LOG2W].side_r;
    assign vf          = lvl[LOG2W].v_r;
    assign s_nxt       = hf ^ gf;
    assign c_top       = (xm & ym) | ((xm ^ ym) & gf[WIDTH-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            s         <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
        end else if (adv) begin
            out_valid <= vf;
            s         <= s_nxt;
            cout      <= c_top;
            ovf       <= c_top ^ gf[WIDTH-1];
            zero      <= ~|s_nxt;
        end
    end

endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// Bench for pipelined_prefix_adder: directed WIDTH=16 vectors, stall and reset cases,
// exhaustive WIDTH=6 and random WIDTH=13 streams against an integer model.
module tb_pipelined_prefix_adder;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected result layout: {cout, ovf, zero, s[63:0]}
    function automatic logic [66:0] model(input int w, input logic [63:0] a, input logic [63:0] b,
                                          input logic c, input logic sb);
        logic [64:0] m, aa, bb, full, sm;
        logic co, ov, z;
        m    = (65'd1 << w) - 65'd1;
        aa   = {1'b0, a} & m;
        bb   = (sb ? ~{1'b0, b} : {1'b0, b}) & m;
        full = aa + bb + {64'd0, (sb | c)};
        sm   = full & m;
        co   = full[w];
        ov   = (aa[w-1] == bb[w-1]) && (sm[w-1] != aa[w-1]);
        z    = (sm == 65'd0);
        return {co, ov, z, sm[63:0]};
    endfunction

    // ---------------- WIDTH = 16 ----------------
    logic        iv16, ir16, cin16, sub16, ov16, or16, co16, of16, z16;
    logic [15:0] x16, y16, s16;
    pipelined_prefix_adder #(.WIDTH(16)) u16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .x(x16), .y(y16),
        .cin(cin16), .sub(sub16), .out_valid(ov16), .out_ready(or16), .s(s16),
        .cout(co16), .ovf(of16), .zero(z16));

    // ---------------- WIDTH = 6 ----------------
    logic       iv6, ir6, cin6, sub6, ov6, or6, co6, of6, z6;
    logic [5:0] x6, y6, s6;
    pipelined_prefix_adder #(.WIDTH(6)) u6 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv6), .in_ready(ir6), .x(x6), .y(y6),
        .cin(cin6), .sub(sub6), .out_valid(ov6), .out_ready(or6), .s(s6),
        .cout(co6), .ovf(of6), .zero(z6));

    // ---------------- WIDTH = 13 ----------------
    logic        iv13, ir13, cin13, sub13, ov13, or13, co13, of13, z13;
    logic [12:0] x13, y13, s13;
    pipelined_prefix_adder #(.WIDTH(13)) u13 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv13), .in_ready(ir13), .x(x13), .y(y13),
        .cin(cin13), .sub(sub13), .out_valid(ov13), .out_ready(or13), .s(s13),
        .cout(co13), .ovf(of13), .zero(z13));

    logic [66:0] q16[$], q6[$], q13[$];
    int          a16[$], a6[$], a13[$];
    int          sa16[$], sa6[$], sa13[$];
    int          st16 = 0, st6 = 0, st13 = 0;

    always @(negedge clk) begin : mon16
        logic [66:0] e;
        int ac, sa;
        if (ov16 && !or16) st16++;
        if (iv16 && ir16) begin
            a16.push_back(cyc + 1);
            sa16.push_back(st16);
        end
        if (ov16 && or16) begin
            check("w16_beat_expected", 64'(q16.size() != 0), 64'd1);
            if (q16.size() != 0 && a16.size() != 0) begin
                e  = q16.pop_front();
                ac = a16.pop_front();
                sa = sa16.pop_front();
                check("w16_s", 64'(s16), e[63:0]);
                check("w16_cout", 64'(co16), 64'(e[66]));
                check("w16_ovf", 64'(of16), 64'(e[65]));
                check("w16_zero", 64'(z16), 64'(e[64]));
                if (sa == st16) check("w16_latency", 64'(cyc + 1 - ac), 64'd6);
            end
        end
    end

    always @(negedge clk) begin : mon6
        logic [66:0] e;
        int ac, sa;
        if (ov6 && !or6) st6++;
        if (iv6 && ir6) begin
            q6.push_back(model(6, 64'(x6), 64'(y6), cin6, sub6));
            a6.push_back(cyc + 1);
            sa6.push_back(st6);
        end
        if (ov6 && or6) begin
            check("w6_beat_expected", 64'(q6.size() != 0), 64'd1);
            if (q6.size() != 0) begin
                e  = q6.pop_front();
                ac = a6.pop_front();
                sa = sa6.pop_front();
                check("w6_s", 64'(s6), e[63:0]);
                check("w6_cout", 64'(co6), 64'(e[66]));
                check("w6_ovf", 64'(of6), 64'(e[65]));
                check("w6_zero", 64'(z6), 64'(e[64]));
                if (sa == st6) check("w6_latency", 64'(cyc + 1 - ac), 64'd5);
            end
        end
    end

    always @(negedge clk) begin : mon13
        logic [66:0] e;
        int ac, sa;
        if (ov13 && !or13) st13++;
        if (iv13 && ir13) begin
            q13.push_back(model(13, 64'(x13), 64'(y13), cin13, sub13));
            a13.push_back(cyc + 1);
            sa13.push_back(st13);
        end
        if (ov13 && or13) begin
            check("w13_beat_expected", 64'(q13.size() != 0), 64'd1);
            if (q13.size() != 0) begin
                e  = q13.pop_front();
                ac = a13.pop_front();
                sa = sa13.pop_front();
                check("w13_s", 64'(s13), e[63:0]);
                check("w13_cout", 64'(co13), 64'(e[66]));
                check("w13_ovf", 64'(of13), 64'(e[65]));
                check("w13_zero", 64'(z13), 64'(e[64]));
                if (sa == st13) check("w13_latency", 64'(cyc + 1 - ac), 64'd6);
            end
        end
    end

    function automatic int qsize(input int w);
        case (w)
            16:      return q16.size();
            6:       return q6.size();
            default: return q13.size();
        endcase
    endfunction

    task automatic drain(input string tag, input int w);
        int n = 0;
        while (qsize(w) != 0 && n < 500) begin
            step();
            n++;
        end
        check(tag, 64'(qsize(w)), 64'd0);
    endtask

    task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic c, input logic sb,
                          input logic [15:0] es, input logic eco, input logic eov, input logic ez);
        int n = 0;
        iv16 = 1'b1; x16 = a; y16 = b; cin16 = c; sub16 = sb;
        q16.push_back({eco, eov, ez, 48'd0, es});
        @(negedge clk);
        while (!ir16 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) check("w16_accept_timeout", 64'(n), 64'd0);
        @(posedge clk);
        #1;
        iv16 = 1'b0;
    endtask

    initial begin
        #950000;
        $display("FAIL watchdog expired cycles=%0d", cyc);
        $fatal(1, "watchdog");
    end

    logic [15:0] hold;
    logic        done6 = 1'b0, done13 = 1'b0;

    initial begin
        rst_n = 1'b0;
        {iv16, cin16, sub16, x16, y16} = '0; or16 = 1'b1;
        {iv6, cin6, sub6, x6, y6} = '0;      or6 = 1'b1;
        {iv13, cin13, sub13, x13, y13} = '0; or13 = 1'b1;
        step(); step();
        check("rst_out_valid16", 64'(ov16), 64'd0);
        check("rst_s16", 64'(s16), 64'd0);
        check("rst_flags16", 64'({co16, of16, z16}), 64'd0);
        check("rst_in_ready16", 64'(ir16), 64'd1);
        check("rst_out_valid6_13", 64'({ov6, ov13}), 64'd0);
        rst_n = 1'b1;
        step(); step();

        // Directed vectors, expected values worked by hand
        send16(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        send16(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        send16(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        send16(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        send16(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        send16(16'h0003, 16'h0003, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
        send16(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);
        drain("w16_drain_directed", 16);

        // Ten back-to-back beats with a 3-cycle downstream stall in the middle
        fork
            for (int i = 0; i < 10; i++)
                send16(16'(i) * 16'h1111, 16'h0101, 1'b0, 1'b0,
                       16'(i) * 16'h1111 + 16'h0101, 1'b0, 1'b0, 1'b0);
            begin
                repeat (8) step();
                or16 = 1'b0;
                @(negedge clk);
                check("w16_stall_in_ready", 64'(ir16), 64'd0);
                check("w16_stall_out_valid", 64'(ov16), 64'd1);
                hold = s16;
                repeat (2) begin
                    step();
                    @(negedge clk);
                    check("w16_stall_in_ready", 64'(ir16), 64'd0);
                    check("w16_stall_s_stable", 64'(s16), 64'(hold));
                end
                step();
                or16 = 1'b1;
            end
        join
        drain("w16_drain_stream", 16);

        // Mid-stream reset with a stalled result at the output and more behind it
        or16 = 1'b0;
        for (int i = 0; i < 4; i++)
            send16(16'h1000 * 16'(i + 1), 16'h0234, 1'b0, 1'b0,
                   16'h1000 * 16'(i + 1) + 16'h0234, 1'b0, 1'b0, 1'b0);
        repeat (3) step();
        check("w16_pre_reset_valid", 64'(ov16), 64'd1);
        rst_n = 1'b0;
        #1;
        check("w16_reset_out_valid", 64'(ov16), 64'd0);
        check("w16_reset_s", 64'(s16), 64'd0);
        check("w16_reset_flags", 64'({co16, of16, z16}), 64'd0);
        q16.delete(); a16.delete(); sa16.delete();
        or16 = 1'b1;
        step();
        rst_n = 1'b1;
        send16(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);
        drain("w16_drain_after_reset", 16);
        repeat (12) step();

        // WIDTH=6 exhaustive at full input rate, random downstream readiness
        fork
            begin
                for (int sb = 0; sb < 2; sb++)
                    for (int c = 0; c < 2; c++)
                        for (int a = 0; a < 64; a++)
                            for (int b = 0; b < 64; b++) begin
                                int n;
                                n = 0;
                                iv6 = 1'b1; x6 = 6'(a); y6 = 6'(b); cin6 = c[0]; sub6 = sb[0];
                                @(negedge clk);
                                while (!ir6 && n < 1000) begin
                                    @(negedge clk);
                                    n++;
                                end
                                if (n >= 1000) check("w6_accept_timeout", 64'(n), 64'd0);
                                @(posedge clk);
                                #1;
                            end
                iv6 = 1'b0;
                done6 = 1'b1;
            end
            begin
                while (!done6) begin
                    or6 = ($urandom_range(0, 3) != 0);
                    step();
                end
                or6 = 1'b1;
            end
        join
        drain("w6_drain", 6);

        // WIDTH=13 random operands with random input gaps and downstream stalls
        fork
            begin
                for (int i = 0; i < 10000; i++) begin
                    int n;
                    n = 0;
                    while ($urandom_range(0, 1) != 0) step();
                    iv13 = 1'b1; x13 = 13'($urandom); y13 = 13'($urandom);
                    cin13 = 1'($urandom); sub13 = 1'($urandom);
                    @(negedge clk);
                    while (!ir13 && n < 1000) begin
                        @(negedge clk);
                        n++;
                    end
                    if (n >= 1000) check("w13_accept_timeout", 64'(n), 64'd0);
                    @(posedge clk);
                    #1;
                    iv13 = 1'b0;
                end
                done13 = 1'b1;
            end
            begin
                while (!done13) begin
                    or13 = ($urandom_range(0, 3) != 0);
                    step();
                end
                or13 = 1'b1;
            end
        join
        drain("w13_drain", 13);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipelined_prefix_adder.md
Name: pipelined_prefix_adder

Overview:
- Parametrised, pipelined Kogge-Stone parallel-prefix adder/subtractor. Replaces the fixed 6-bit combinational prefix adder with one that scales to any WIDTH.
- Adds carry-in, an add/sub mode, signed-overflow, carry-out and zero flags, and one register per prefix level.
- Uses a valid/ready handshake with backpressure, and sits in the datapath between the operand and result buffers.

Parameters:
- WIDTH, 16, operand and sum width in bits; legal range 2..64.
- LOG2W, $clog2(WIDTH), number of prefix levels; derived, never overridden.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand beat offered
- in_ready  out  1  block accepts beat this cycle
- x  in  WIDTH  operand A
- y  in  WIDTH  operand B
- cin  in  1  carry-in; used only when sub=0
- sub  in  1  1 = subtract (x - y), 0 = add (x + y + cin)
- out_valid  out  1  result beat present
- out_ready  in  1  downstream accepts result
- s  out  WIDTH  sum/difference
- cout  out  1  carry out of MSB; for subtraction 1 = no borrow
- ovf  out  1  two's-complement signed overflow
- zero  out  1  s == 0

Behaviour:
- Clock and reset:
  - One clock, clk. Reset rst_n is asynchronous and active-low.
  - While rst_n=0: every valid bit, every data/flag register and all outputs are 0. in_ready=1 once out_ready permits (see below).
- Pipeline structure, total latency L = LOG2W + 2 cycles from accept to out_valid:
  - Stage 0: register the operands with y' = sub ? ~y : y and c0 = sub ? 1 : cin. Then compute bitwise g = x&y', p = x^y'. The carry-in is folded in as the prefix-0 generate: G[-1] = c0.
  - Stages 1..LOG2W: prefix level k combines (G,P) at bit i with bit i-2^(k-1) when i-2^(k-1) >= -1. Otherwise it passes through. The result is registered, along with the half-sum h=p, c0, x[MSB] and y'[MSB].
  - Final stage: s[i] = h[i] ^ C[i-1] with C[-1]=c0; cout = C[WIDTH-1]; ovf = C[WIDTH-1] ^ C[WIDTH-2]; zero = ~|s. All are registered.
- Handshake:
  - The pipeline uses a global enable: adv = ~out_valid | out_ready. in_ready = adv.
  - When adv=1, all stages shift one step; each stage's valid takes the previous stage's valid, and stage 0's valid takes in_valid.
  - When adv=0, all stages hold. Bubbles are not compressed.
  - A beat is accepted when in_valid & in_ready. A result is consumed when out_valid & out_ready.
  - in_ready depends combinationally on out_ready only, never on in_valid.
- Outputs s/cout/ovf/zero are stable while out_valid=1 and out_ready=0.
- Registers with valid=0 may hold stale data. Outputs are don't-care when out_valid=0, except after reset, where they are 0.
- Throughput is one result per cycle while out_ready=1. Results leave strictly in accept order.
- Boundary cases:
  - WIDTH not a power of two: the prefix tree is truncated at the MSB. Latency still uses $clog2.
  - sub=1 ignores cin.
  - x=y=all-ones with cin=1: s = all-ones, cout=1.
  - Accept and consume in the same cycle with a full pipeline is legal and loses no data.
  - rst_n asserted mid-stream: in-flight beats are discarded and out_valid drops asynchronously. After release, the first accepted beat appears L cycles later.
- No combinational path from x/y/cin/sub to any output.

Test Plan:
- WIDTH=16, add 0x7FFF + 0x0001, cin=0, out_ready=1 → 6 cycles later out_valid=1, s=0x8000, ovf=1, cout=0, zero=0.
- WIDTH=16, add 0xFFFF + 0x0000, cin=1 → s=0x0000, cout=1, zero=1, ovf=0. Then sub 0x0005 - 0x0007 → s=0xFFFE, cout=0, ovf=0. Then sub 0x8000 - 0x0001 → s=0x7FFF, ovf=1, cout=1.
- Stream 10 back-to-back beats, holding out_ready=0 for 3 cycles mid-stream:
  - in_ready=0 during the stall.
  - s stays stable while stalled.
  - All 10 results arrive in order, none lost or duplicated.
- Pulse rst_n low for 1 cycle with 4 beats in flight → out_valid=0 immediately and all outputs 0. None of the 4 results ever appears. A new beat accepted after release appears exactly 6 cycles later.
- WIDTH=6 (L=5): exhaustive x, y, cin, sub (16384 vectors) streamed at full rate with random out_ready → every s/cout/ovf/zero matches the integer model.
- WIDTH=13 (L=6): 10k random vectors with random in_valid/out_ready → model match, and the latency check shows accept-to-valid equal to 6 whenever unstalled.
